// File: rtl/tmcu_pkg.sv
// tmcu_pkg: shared types and defaults for the TMCU SRAM controller.
//   - SRAM_BASE_DEF / SRAM_BYTES_DEF : default SRAM window (base byte address, size)
//   - state_e : controller FSM states
//   - op_e    : access kind decoded when a request is accepted
//   - rsp_t   : registered response payload (rdata, err)
package tmcu_pkg;

  localparam logic [31:0] SRAM_BASE_DEF  = 32'h2000_0000;
  localparam int unsigned SRAM_BYTES_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    RD_CAP,
    RMW_WR,
    RSP
  } state_e;

  // OP_NONE covers everything that touches no SRAM: address/alignment errors,
  // be==0 writes and (without read-modify-write) partial writes.
  typedef enum logic [1:0] {
    OP_NONE,
    OP_RD,
    OP_WR,
    OP_RMW
  } op_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

endpackage

// File: rtl/tmcu_sram_be_merge.sv
// tmcu_sram_be_merge: combinational byte-enable merge for partial writes.
//   old_i    : word currently stored in SRAM
//   new_i    : write data from the request
//   be_i     : byte enables (bit n selects new_i byte n)
//   merged_o : old_i with the enabled bytes replaced by new_i
module tmcu_sram_be_merge
  import tmcu_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [3:0]  be_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be_i[i]) begin
        merged_o[8*i +: 8] = new_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/tmcu_sram_ctrl.sv
// tmcu_sram_ctrl: single-outstanding request/response bridge to a synchronous SRAM.
// Build option: define TMCU_SRAM_RMW_EN to serve partial byte-enable writes as
// read-modify-write; otherwise such writes are answered with an error.
// Ports:
//   clk, rst_n                       : clock (posedge), asynchronous active-low reset
//   req_valid/req_ready              : request handshake
//   req_we, req_addr, req_wdata, req_be : request payload (byte address)
//   rsp_valid/rsp_ready              : response handshake
//   rsp_rdata, rsp_err               : response payload
//   sram_addr, sram_wdata            : SRAM byte offset within the window, write data
//   sram_rdata                       : SRAM read data, valid one edge after sram_read
//   sram_read, sram_write            : single-cycle SRAM strobes
module tmcu_sram_ctrl
  import tmcu_pkg::*;
#(
  parameter logic [31:0] SRAM_BASE  = SRAM_BASE_DEF,
  parameter int unsigned SRAM_BYTES = SRAM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic        sram_write,
  output logic        sram_read
);

  state_e      state_q, state_d;
  op_e         op_q;
  logic [31:0] off_q;
  logic [31:0] wdata_q;
  logic        err_q;
  rsp_t        rsp_q;

  logic [31:0] req_off;
  logic        in_win;
  logic        aligned;
  logic        err_dec;
  op_e         op_dec;
  logic        accept;
  logic        rd_stb;
  logic        wr_stb;
  logic [31:0] wr_word;

`ifdef TMCU_SRAM_RMW_EN
  logic [3:0]  be_q;
  logic [31:0] merged;

  tmcu_sram_be_merge u_merge (
    .old_i    (sram_rdata),
    .new_i    (wdata_q),
    .be_i     (be_q),
    .merged_o (merged)
  );
`endif

  // Decode at accept time. The window test uses the offset so that a window
  // ending at the top of the address space cannot wrap.
  always_comb begin
    req_off = req_addr - SRAM_BASE;
    in_win  = (req_addr >= SRAM_BASE) && (req_off < SRAM_BYTES);
    aligned = (req_addr[1:0] == 2'b00);
    err_dec = !(in_win && aligned);
    op_dec  = OP_NONE;
    if (!err_dec) begin
      if (!req_we) begin
        op_dec = OP_RD;
      end else if (req_be == 4'hF) begin
        op_dec = OP_WR;
      end else if (req_be != 4'h0) begin
`ifdef TMCU_SRAM_RMW_EN
        op_dec = OP_RMW;
`else
        err_dec = 1'b1;
`endif
      end
    end
  end

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ACCESS;
      end
      ACCESS: begin
        case (op_q)
          OP_RD:   state_d = RD_CAP;
          OP_RMW:  state_d = RMW_WR;
          default: state_d = RSP;
        endcase
      end
      RD_CAP:  state_d = RSP;
      RMW_WR:  state_d = RSP;
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. req_ready is gated by rst_n so it reads 0 while reset is held
  // even though the state register already sits in IDLE.
  always_comb begin
    rd_stb = (state_q == ACCESS) && ((op_q == OP_RD) || (op_q == OP_RMW));
    wr_stb = (state_q == ACCESS) && (op_q == OP_WR);
    wr_word = wdata_q;
`ifdef TMCU_SRAM_RMW_EN
    if (state_q == RMW_WR) begin
      wr_stb  = 1'b1;
      wr_word = merged;
    end
`endif
    req_ready  = (state_q == IDLE) && rst_n;
    sram_read  = rd_stb;
    sram_write = wr_stb;
    sram_addr  = (rd_stb || wr_stb) ? off_q : '0;
    sram_wdata = wr_stb ? wr_word : '0;
    rsp_valid  = (state_q == RSP);
    rsp_rdata  = rsp_q.rdata;
    rsp_err    = rsp_q.err;
  end

  // Request capture and response payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_NONE;
      off_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rsp_q   <= '0;
`ifdef TMCU_SRAM_RMW_EN
      be_q    <= '0;
`endif
    end else begin
      if (accept) begin
        op_q    <= op_dec;
        off_q   <= req_off;
        wdata_q <= req_wdata;
        err_q   <= err_dec;
`ifdef TMCU_SRAM_RMW_EN
        be_q    <= req_be;
`endif
      end
      case (state_q)
        ACCESS: begin
          if ((op_q == OP_NONE) || (op_q == OP_WR)) begin
            rsp_q.rdata <= '0;
            rsp_q.err   <= err_q;
          end
        end
        RD_CAP: begin
          rsp_q.rdata <= sram_rdata;
          rsp_q.err   <= 1'b0;
        end
        RMW_WR: begin
          rsp_q.rdata <= '0;
          rsp_q.err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tmcu_sram_ctrl.sv
// tb_tmcu_sram_ctrl: self-checking bench for tmcu_sram_ctrl with a synchronous
// SRAM model. Expectations follow TMCU_SRAM_RMW_EN the same way as the design.
module tb_tmcu_sram_ctrl;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int unsigned BYTES = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_write;
  logic        sram_read;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        mem_init = 1'b1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    int          lat;
    int          nrd;
    int          nwr;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rdata;
    logic        err;
    logic        both;
    logic        hold_bad;
    logic        rdy_bad;
    logic        timeout;
  } obs_t;

  typedef struct packed {
    int          lat;
    int          nrd;
    int          nwr;
    int          wr_cyc;
    logic        err;
    logic [31:0] rdata;
    logic        upd;
    logic [31:0] word;
  } exp_t;

  tmcu_sram_ctrl #(
    .SRAM_BASE  (BASE),
    .SRAM_BYTES (BYTES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_write (sram_write),
    .sram_read  (sram_read)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int unsigned i);
    return (i * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  // Synchronous 4KB SRAM: read data registered one edge after sram_read.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(unsigned'(i));
    end else begin
      if (sram_read)  sram_rdata <= mem[sram_addr[11:2]];
      if (sram_write) mem[sram_addr[11:2]] <= sram_wdata;
    end
  end

  // Outcome model: what a transaction should produce, from the request alone
  // and the reference memory contents.
  function automatic exp_t model(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    logic [31:0] off;
    logic        ok;
    e   = '0;
    e.lat = 2;
    off = addr - BASE;
    ok  = (addr[1:0] == 2'b00) && (addr >= BASE) && (off < BYTES);
    if (!ok) begin
      e.err = 1'b1;
    end else if (!we) begin
      e.lat = 3; e.nrd = 1; e.rdata = ref_mem[off[11:2]];
    end else if (be == 4'hF) begin
      e.nwr = 1; e.wr_cyc = 1; e.upd = 1'b1; e.word = wdata;
    end else if (be != 4'h0) begin
`ifdef TMCU_SRAM_RMW_EN
      begin
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        e.lat = 3; e.nrd = 1; e.nwr = 1; e.wr_cyc = 2; e.upd = 1'b1;
        e.word = (ref_mem[off[11:2]] & ~mask) | (wdata & mask);
      end
`else
      e.err = 1'b1;
`endif
    end
    return e;
  endfunction

  // Drives one request, observes strobes and the response, optionally holds
  // rsp_ready low for 'hold' cycles while offering a competing request.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold, output obs_t o);
    int k;
    int w;
    o = '0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    w = 0;
    while (req_ready !== 1'b1 && w < 20) begin
      @(negedge clk); w++;
    end
    if (req_ready !== 1'b1) begin
      o.timeout = 1'b1; req_valid = 1'b0; return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    k = 1;
    while (1) begin
      if (sram_read === 1'b1)  begin o.nrd = o.nrd + 1; o.rd_cyc = k; o.rd_addr = sram_addr; end
      if (sram_write === 1'b1) begin
        o.nwr = o.nwr + 1; o.wr_cyc = k; o.wr_addr = sram_addr; o.wr_data = sram_wdata;
      end
      if (sram_read === 1'b1 && sram_write === 1'b1) o.both = 1'b1;
      if (req_ready !== 1'b0) o.rdy_bad = 1'b1;
      if (rsp_valid === 1'b1 || k >= 8) break;
      @(negedge clk); k++;
    end
    if (rsp_valid !== 1'b1) begin
      o.timeout = 1'b1; return;
    end
    o.lat = k; o.rdata = rsp_rdata; o.err = rsp_err;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_we = 1'($urandom); req_be = 4'hF; req_wdata = $urandom;
      req_addr = BASE + ($urandom & 32'hFFC);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_err !== o.err ||
          req_ready !== 1'b0 || sram_read !== 1'b0 || sram_write !== 1'b0)
        o.hold_bad = 1'b1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) o.rdy_bad = 1'b1;
    if (sram_read !== 1'b0 || sram_write !== 1'b0) o.hold_bad = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready);
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, sram_read, sram_write} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got vld/err/rd/wr=%b%b%b%b want 0000", rsp_valid, rsp_err, sram_read, sram_write);
    end
    n_cmp++;
    if ({rsp_rdata, sram_addr, sram_wdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0", rsp_rdata, sram_addr, sram_wdata);
    end
    mem_init = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(unsigned'(i));
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    obs_t o;
    run_txn(1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 0, o);
    n_cmp++;
    if ({o.timeout, o.nrd, o.nwr, o.wr_cyc, o.wr_addr, o.wr_data} !== {1'b0, 32'd0, 32'd1, 32'd1, 32'h10, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL wr_strobe: got to=%b nrd=%0d nwr=%0d cyc=%0d addr=%h data=%h want 0/0/1/1/10/deadbeef",
               o.timeout, o.nrd, o.nwr, o.wr_cyc, o.wr_addr, o.wr_data);
    end
    n_cmp++;
    if ({o.lat, o.err, o.rdata} !== {32'd2, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL wr_rsp: got lat=%0d err=%b rdata=%h want 2/0/0", o.lat, o.err, o.rdata);
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    run_txn(1'b0, 32'h2000_0010, 32'h0, 4'h0, 0, o);
    n_cmp++;
    if ({o.nrd, o.rd_cyc, o.rd_addr, o.nwr} !== {32'd1, 32'd1, 32'h10, 32'd0}) begin
      n_fail++;
      $display("FAIL rd_strobe: got nrd=%0d cyc=%0d addr=%h nwr=%0d want 1/1/10/0", o.nrd, o.rd_cyc, o.rd_addr, o.nwr);
    end
    n_cmp++;
    if ({o.lat, o.err, o.rdata} !== {32'd3, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL rd_rsp: got lat=%0d err=%b rdata=%h want 3/0/deadbeef", o.lat, o.err, o.rdata);
    end
  endtask

  task automatic test_partial();
    obs_t        o;
    logic [31:0] want_word;
    run_txn(1'b1, 32'h2000_0040, 32'h1122_3344, 4'hF, 0, o);
    ref_mem[16] = 32'h1122_3344;
    run_txn(1'b1, 32'h2000_0040, 32'h0000_5500, 4'b0010, 0, o);
`ifdef TMCU_SRAM_RMW_EN
    want_word = 32'h1122_5544;
    n_cmp++;
    if ({o.nrd, o.rd_cyc, o.nwr, o.wr_cyc, o.wr_addr, o.wr_data} !== {32'd1, 32'd1, 32'd1, 32'd2, 32'h40, 32'h1122_5544}) begin
      n_fail++;
      $display("FAIL rmw_strobe: got nrd=%0d rc=%0d nwr=%0d wc=%0d addr=%h data=%h want 1/1/1/2/40/11225544",
               o.nrd, o.rd_cyc, o.nwr, o.wr_cyc, o.wr_addr, o.wr_data);
    end
    n_cmp++;
    if ({o.lat, o.err, o.rdata} !== {32'd3, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL rmw_rsp: got lat=%0d err=%b rdata=%h want 3/0/0", o.lat, o.err, o.rdata);
    end
`else
    want_word = 32'h1122_3344;
    n_cmp++;
    if ({o.nrd, o.nwr} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL partial_strobe: got nrd=%0d nwr=%0d want 0/0", o.nrd, o.nwr);
    end
    n_cmp++;
    if ({o.lat, o.err, o.rdata} !== {32'd2, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL partial_rsp: got lat=%0d err=%b rdata=%h want 2/1/0", o.lat, o.err, o.rdata);
    end
`endif
    ref_mem[16] = want_word;
    run_txn(1'b0, 32'h2000_0040, 32'h0, 4'h0, 0, o);
    n_cmp++;
    if (o.rdata !== want_word || o.err !== 1'b0) begin
      n_fail++; $display("FAIL partial_readback: got %h err=%b want %h err=0", o.rdata, o.err, want_word);
    end
  endtask

  task automatic test_errors();
    obs_t        o;
    logic [31:0] bad [5];
    logic        wr  [5];
    bad = '{32'h2000_1000, 32'h2000_0002, 32'h1FFF_FFFC, 32'h2000_0FFF, 32'h2000_1000};
    wr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_txn(wr[i], bad[i], 32'hFFFF_FFFF, 4'hF, 0, o);
      n_cmp++;
      if ({o.nrd, o.nwr, o.lat, o.err, o.rdata, o.timeout} !== {32'd0, 32'd0, 32'd2, 1'b1, 32'h0, 1'b0}) begin
        n_fail++;
        $display("FAIL err_addr %h: got nrd=%0d nwr=%0d lat=%0d err=%b rdata=%h to=%b want 0/0/2/1/0/0",
                 bad[i], o.nrd, o.nwr, o.lat, o.err, o.rdata, o.timeout);
      end
    end
    run_txn(1'b0, 32'h2000_0FFC, 32'h0, 4'h0, 0, o);
    n_cmp++;
    if ({o.err, o.rdata, o.rd_addr} !== {1'b0, ref_mem[1023], 32'hFFC}) begin
      n_fail++;
      $display("FAIL last_word: got err=%b rdata=%h addr=%h want 0/%h/ffc", o.err, o.rdata, o.rd_addr, ref_mem[1023]);
    end
  endtask

  task automatic test_backpressure();
    obs_t o;
    int   diff;
    run_txn(1'b0, 32'h2000_0010, 32'h0, 4'h0, 5, o);
    n_cmp++;
    if ({o.rdata, o.err} !== {ref_mem[4], 1'b0}) begin
      n_fail++; $display("FAIL bp_rsp: got rdata=%h err=%b want %h/0", o.rdata, o.err, ref_mem[4]);
    end
    n_cmp++;
    if ({o.hold_bad, o.rdy_bad, o.nwr} !== {1'b0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL bp_hold: got hold_bad=%b rdy_bad=%b nwr=%0d want 0/0/0", o.hold_bad, o.rdy_bad, o.nwr);
    end
    diff = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diff++;
    n_cmp++;
    if (diff != 0) begin
      n_fail++; $display("FAIL bp_mem: got %0d changed words want 0", diff);
    end
  endtask

  task automatic test_reset_mid();
    int   stray;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h2000_0020; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++;
    if (sram_write !== 1'b1) begin
      n_fail++; $display("FAIL mid_access_write: got %b want 1", sram_write);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sram_read, sram_write, rsp_valid, req_ready, sram_addr, sram_wdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got rd=%b wr=%b vld=%b rdy=%b addr=%h wdata=%h want all 0",
               sram_read, sram_write, rsp_valid, req_ready, sram_addr, sram_wdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_release_ready: got %b want 1", req_ready);
    end
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || sram_write !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray != 0 || mem[8] !== ref_mem[8]) begin
      n_fail++; $display("FAIL mid_no_response: got stray=%0d mem=%h want 0/%h", stray, mem[8], ref_mem[8]);
    end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic        we;
    logic [31:0] addr, wdata, off;
    logic [3:0]  be;
    int          r;
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      addr = BASE + (($urandom & 32'hFFC) | 32'($urandom_range(1, 3)));
      else if (r == 1) addr = ($urandom_range(0, 1) == 0) ? BASE - 32'h4 - ($urandom & 32'hFC)
                                                          : BASE + BYTES + ($urandom & 32'hFFC);
      else if (r < 7)  addr = BASE + (32'($urandom_range(0, 15)) << 2);
      else             addr = BASE + ($urandom & 32'hFFC);
      we    = 1'($urandom);
      wdata = $urandom;
      be    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      off   = addr - BASE;
      e = model(we, addr, wdata, be);
      run_txn(we, addr, wdata, be, $urandom_range(0, 3), o);
      n_cmp++;
      if ({o.timeout, o.lat, o.err, o.rdata} !== {1'b0, e.lat, e.err, e.rdata}) begin
        n_fail++;
        $display("FAIL rand[%0d] rsp a=%h we=%b be=%h: got to=%b lat=%0d err=%b rdata=%h want 0/%0d/%b/%h",
                 t, addr, we, be, o.timeout, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
      end
      n_cmp++;
      if ({o.nrd, o.rd_cyc, o.rd_addr} !== {e.nrd, e.nrd, (e.nrd != 0) ? off : 32'h0}) begin
        n_fail++;
        $display("FAIL rand[%0d] read_strobe: got n=%0d cyc=%0d addr=%h want n=%0d cyc=%0d",
                 t, o.nrd, o.rd_cyc, o.rd_addr, e.nrd, e.nrd);
      end
      n_cmp++;
      if ({o.nwr, o.wr_cyc, o.wr_addr, o.wr_data} !==
          {e.nwr, e.wr_cyc, (e.nwr != 0) ? off : 32'h0, (e.nwr != 0) ? e.word : 32'h0}) begin
        n_fail++;
        $display("FAIL rand[%0d] write_strobe: got n=%0d cyc=%0d addr=%h data=%h want n=%0d cyc=%0d data=%h",
                 t, o.nwr, o.wr_cyc, o.wr_addr, o.wr_data, e.nwr, e.wr_cyc, e.word);
      end
      n_cmp++;
      if ({o.both, o.hold_bad, o.rdy_bad} !== 3'b000) begin
        n_fail++;
        $display("FAIL rand[%0d] protocol: got both=%b hold_bad=%b rdy_bad=%b want 000", t, o.both, o.hold_bad, o.rdy_bad);
      end
      if (e.upd) ref_mem[off[11:2]] = e.word;
    end
  endtask

  task automatic test_final_mem();
    int diff;
    diff = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diff++;
    n_cmp++;
    if (diff != 0) begin
      n_fail++; $display("FAIL final_mem: got %0d differing words want 0", diff);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_final_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tmcu_sram_ctrl.md
TMCU_SRAM_CTRL -- requirements
Module: tmcu_sram_ctrl

Interface
REQ-001 SHALL have parameter SRAM_BASE, default 32'h2000_0000, byte base address of the SRAM window.
REQ-002 SHALL have parameter SRAM_BYTES, default 4096, SRAM window size in bytes (power of two).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req_valid/req_ready (in/out, 1), req_we (in, 1), req_addr (in, 32), req_wdata (in, 32), req_be (in, 4): request channel.
REQ-006 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_rdata (out, 32), rsp_err (out, 1): response channel.
REQ-007 SHALL have ports sram_addr (out, 32), sram_wdata (out, 32), sram_rdata (in, 32), sram_write (out, 1), sram_read (out, 1): downstream port to the 4KB synchronous SRAM (rdata registered one edge after sram_read).

Function
REQ-008 SHALL hold one outstanding request; req_ready = 1 only in IDLE; accept on req_valid && req_ready at edge E0, registering addr/wdata/be/we.
REQ-009 SHALL use states IDLE, ACCESS, RD_CAP, RMW_WR, RSP.
REQ-010 SHALL flag error when addr[1:0] != 0 or addr outside [SRAM_BASE, SRAM_BASE+SRAM_BYTES); errored requests SHALL assert neither SRAM strobe.
REQ-011 SHALL, for reads: ACCESS drives sram_read=1 (SRAM samples at E1), RD_CAP loads rsp_rdata from sram_rdata at E2, rsp_valid=1 from E2.
REQ-012 SHALL, for writes with be=4'hF: ACCESS drives sram_write=1 with wdata, rsp_valid=1 from E1.
REQ-013 SHALL, for writes with be=0: no SRAM strobe, rsp_err=0, rsp_valid=1 from E1.
REQ-014 SHALL, for errored requests: rsp_err=1, rsp_rdata=0, rsp_valid=1 from E1.
REQ-015 SHALL drive sram_addr = req_addr - SRAM_BASE (byte address, low two bits 0) whenever a strobe is asserted.
REQ-016 SHALL hold rsp_valid/rsp_rdata/rsp_err stable in RSP until rsp_ready; on rsp_valid && rsp_ready return to IDLE, with req_ready=1 the following cycle (no same-cycle accept).
REQ-017 SHALL assert at most one of sram_read/sram_write in any cycle, each for exactly one cycle per access.
REQ-018 SHALL zero rsp_rdata for writes.

Reset
REQ-019 SHALL, on rst_n low (any time, incl. mid-access or while in RSP), immediately enter IDLE, drop sram_read/sram_write/rsp_valid/rsp_err to 0, clear rsp_rdata/sram_addr/sram_wdata to 0, req_ready=0 while rst_n is low; the in-flight request is discarded without response.
REQ-020 SHALL have req_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-021 SHALL implement partial writes under macro TMCU_SRAM_RMW_EN: with it defined, partial-be writes (be not 0, not F) do ACCESS read (E1), RMW_WR writes per-byte merge of wdata over sram_rdata (E2), rsp_valid from E2, rsp_err=0.
REQ-022 SHALL, without TMCU_SRAM_RMW_EN, answer partial-be writes with rsp_err=1 from E1 and no SRAM strobe.

Structure
REQ-023 SHALL place the state enum, SRAM_BASE/SRAM_BYTES defaults and the response struct (rdata, err) in package tmcu_pkg.
REQ-024 SHALL implement byte merge in sub-module tmcu_sram_be_merge (combinational: old, new, be -> merged), instantiated only under TMCU_SRAM_RMW_EN.

Verification
REQ-025 Write addr 0x2000_0010, data 0xDEADBEEF, be F; read same -> sram_write once at E1 with sram_addr 0x10; read rsp_rdata 0xDEADBEEF at E2, rsp_err 0.
REQ-026 Write be 4'b0010 data 0x0000_5500 over 0x1122_3344 -> with macro: read then write 0x1122_5544, rsp_err 0; without: rsp_err 1, memory unchanged.
REQ-027 Read 0x2000_1000 and 0x2000_0002 -> rsp_err 1, rsp_rdata 0, no SRAM strobe.
REQ-028 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata stable, req_ready 0, new req_valid ignored.
REQ-029 Assert rst_n=0 in ACCESS of a write -> strobes/rsp_valid 0 immediately, no response, req_ready 1 first cycle after release.
